// File: rtl/cmt_trace_queue_pkg.sv
// Shared constants, FSM encoding and entry-layout helpers for the difftest commit queue.
// Entry layout (MSB..LSB): {trap, a0b, skip, wen, rd, wdata, inst, pc}.
package cmt_trace_queue_pkg;

  localparam logic [6:0]  TRAP_OPCODE = 7'h6b;
  localparam int unsigned RIDX_W      = 5;
  localparam int unsigned INST_W      = 32;
  localparam int unsigned CODE_W      = 8;

  typedef enum logic {
    ST_RUN,
    ST_TRAP
  } trap_state_e;

  function automatic int unsigned entry_w(input int unsigned xlen);
    return 1 + CODE_W + 1 + 1 + RIDX_W + xlen + INST_W + xlen;
  endfunction

  function automatic logic is_trap(input logic [INST_W-1:0] inst);
    return inst[6:0] == TRAP_OPCODE;
  endfunction

endpackage

// File: rtl/cmt_trace_queue_if.sv
// Retire-side inputs and difftest commit/trap outputs of cmt_trace_queue.
interface cmt_trace_queue_if #(
  parameter int unsigned NIN   = 2,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned XLEN  = 64
);
  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

  logic [NIN-1:0]      i_valid;
  logic [NIN*XLEN-1:0] i_pc;
  logic [NIN*32-1:0]   i_inst;
  logic [NIN-1:0]      i_rd_wen;
  logic [NIN*5-1:0]    i_rd;
  logic [NIN*XLEN-1:0] i_rd_wdata;
  logic [NIN-1:0]      i_skip;
  logic [XLEN-1:0]     i_a0;
  logic [31:0]         i_intrNo;

  logic                o_ready;
  logic                o_cmt_valid;
  logic [XLEN-1:0]     o_cmt_pc;
  logic [31:0]         o_cmt_inst;
  logic                o_cmt_skip;
  logic                o_cmt_wen;
  logic [7:0]          o_cmt_wdest;
  logic [XLEN-1:0]     o_cmt_wdata;
  logic [31:0]         o_intr_no;
  logic [XLEN-1:0]     o_intr_pc;
  logic                o_trap;
  logic [7:0]          o_trap_code;
  logic [XLEN-1:0]     o_trap_pc;
  logic [63:0]         o_cycle_cnt;
  logic [63:0]         o_instr_cnt;
  logic [OCC_W-1:0]    o_occupancy;
  logic                o_overflow;

  modport master (
    output i_valid, i_pc, i_inst, i_rd_wen, i_rd, i_rd_wdata, i_skip, i_a0, i_intrNo,
    input  o_ready, o_cmt_valid, o_cmt_pc, o_cmt_inst, o_cmt_skip, o_cmt_wen,
           o_cmt_wdest, o_cmt_wdata, o_intr_no, o_intr_pc, o_trap, o_trap_code,
           o_trap_pc, o_cycle_cnt, o_instr_cnt, o_occupancy, o_overflow
  );

  modport slave (
    input  i_valid, i_pc, i_inst, i_rd_wen, i_rd, i_rd_wdata, i_skip, i_a0, i_intrNo,
    output o_ready, o_cmt_valid, o_cmt_pc, o_cmt_inst, o_cmt_skip, o_cmt_wen,
           o_cmt_wdest, o_cmt_wdata, o_intr_no, o_intr_pc, o_trap, o_trap_code,
           o_trap_pc, o_cycle_cnt, o_instr_cnt, o_occupancy, o_overflow
  );

endinterface

// File: rtl/cmt_lane_pack.sv
// Builds one queue entry per retire lane and compacts the valid ones into the
// low slots in ascending lane order, with the number of valid lanes.
module cmt_lane_pack
  import cmt_trace_queue_pkg::*;
#(
  parameter  int unsigned NIN  = 2,
  parameter  int unsigned XLEN = 64,
  localparam int unsigned EW   = entry_w(XLEN),
  localparam int unsigned CW   = $clog2(NIN) + 1
) (
  input  logic [NIN-1:0]        valid,
  input  logic [NIN*XLEN-1:0]   pc,
  input  logic [NIN*INST_W-1:0] inst,
  input  logic [NIN-1:0]        rd_wen,
  input  logic [NIN*RIDX_W-1:0] rd,
  input  logic [NIN*XLEN-1:0]   rd_wdata,
  input  logic [NIN-1:0]        skip,
  input  logic [CODE_W-1:0]     a0b,
  output logic [NIN*EW-1:0]     packed_entries,
  output logic [CW-1:0]         count
);

  logic [EW-1:0] lane_entry [NIN];

  for (genvar k = 0; k < NIN; k++) begin : g_lane
    logic [INST_W-1:0] lane_inst;
    logic              lane_trap;

    assign lane_inst     = inst[k*INST_W +: INST_W];
    assign lane_trap     = is_trap(lane_inst);
    assign lane_entry[k] = {lane_trap, (lane_trap ? a0b : '0), skip[k], rd_wen[k],
                            rd[k*RIDX_W +: RIDX_W], rd_wdata[k*XLEN +: XLEN],
                            lane_inst, pc[k*XLEN +: XLEN]};
  end

  // Slot index of a valid lane equals the number of valid lanes below it.
  always_comb begin
    int unsigned slot;
    packed_entries = '0;
    slot           = 0;
    for (int unsigned k = 0; k < NIN; k++) begin
      if (valid[k]) begin
        packed_entries[slot*EW +: EW] = lane_entry[k];
        slot = slot + 1;
      end
    end
    count = CW'(slot);
  end

endmodule

// File: rtl/cmt_trace_queue.sv
// Multi-lane retire buffer feeding the single-lane difftest commit and trap ports;
// the first drained trap instruction freezes the queue and counters until reset.
module cmt_trace_queue
  import cmt_trace_queue_pkg::*;
#(
  parameter int unsigned NIN   = 2,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned XLEN  = 64
) (
  input logic             clk,
  input logic             rst,
  cmt_trace_queue_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = AW + 1;
  localparam int unsigned EW = entry_w(XLEN);
  localparam int unsigned CW = $clog2(NIN) + 1;

  logic [NIN*EW-1:0] packed_entries;
  logic [CW-1:0]     lane_cnt;

  logic [EW-1:0]     mem [DEPTH];
  logic [AW-1:0]     head, tail;
  logic [OW-1:0]     occ;
  logic [OW-1:0]     n_in;
  logic              ready, enq, deq, trap_hit;
  trap_state_e       state, state_nxt;

  logic              h_trap;
  logic [CODE_W-1:0] h_code;
  logic              h_skip, h_wen;
  logic [RIDX_W-1:0] h_rd;
  logic [XLEN-1:0]   h_wdata;
  logic [INST_W-1:0] h_inst;
  logic [XLEN-1:0]   h_pc;

  logic              unused_a0_hi;
  assign unused_a0_hi = ^bus.i_a0[XLEN-1:CODE_W];

  cmt_lane_pack #(
    .NIN  (NIN),
    .XLEN (XLEN)
  ) u_lane_pack (
    .valid          (bus.i_valid),
    .pc             (bus.i_pc),
    .inst           (bus.i_inst),
    .rd_wen         (bus.i_rd_wen),
    .rd             (bus.i_rd),
    .rd_wdata       (bus.i_rd_wdata),
    .skip           (bus.i_skip),
    .a0b            (bus.i_a0[CODE_W-1:0]),
    .packed_entries (packed_entries),
    .count          (lane_cnt)
  );

  assign {h_trap, h_code, h_skip, h_wen, h_rd, h_wdata, h_inst, h_pc} = mem[head];

  // Readiness looks only at the registered count, never at this cycle's drain.
  always_comb begin
    ready = (state == ST_RUN) && ((OW'(DEPTH) - occ) >= OW'(NIN));
    enq   = ready && (bus.i_intrNo == '0);
    n_in  = enq ? OW'(lane_cnt) : '0;
    deq   = (occ != '0) && (state == ST_RUN);
  end

  assign bus.o_ready     = ready;
  assign bus.o_occupancy = occ;
  assign bus.o_trap      = (state == ST_TRAP);

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_RUN;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    trap_hit  = 1'b0;
    case (state)
      ST_RUN: begin
        if (deq && h_trap) begin
          state_nxt = ST_TRAP;
          trap_hit  = 1'b1;
        end
      end
      ST_TRAP: state_nxt = ST_TRAP;
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    for (int unsigned j = 0; j < NIN; j++) begin
      if (OW'(j) < n_in) mem[tail + AW'(j)] <= packed_entries[j*EW +: EW];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head             <= '0;
      tail             <= '0;
      occ              <= '0;
      bus.o_cmt_valid  <= 1'b0;
      bus.o_cmt_pc     <= '0;
      bus.o_cmt_inst   <= '0;
      bus.o_cmt_skip   <= 1'b0;
      bus.o_cmt_wen    <= 1'b0;
      bus.o_cmt_wdest  <= '0;
      bus.o_cmt_wdata  <= '0;
      bus.o_intr_no    <= '0;
      bus.o_intr_pc    <= '0;
      bus.o_trap_code  <= '0;
      bus.o_trap_pc    <= '0;
      bus.o_cycle_cnt  <= '0;
      bus.o_instr_cnt  <= '0;
      bus.o_overflow   <= 1'b0;
    end else begin
      tail            <= tail + AW'(n_in);
      head            <= head + AW'(deq);
      occ             <= occ + n_in - OW'(deq);
      bus.o_cmt_valid <= deq;
      if (deq) begin
        bus.o_cmt_pc    <= h_pc;
        bus.o_cmt_inst  <= h_inst;
        bus.o_cmt_skip  <= h_skip;
        bus.o_cmt_wen   <= h_wen;
        bus.o_cmt_wdest <= {3'd0, h_rd};
        bus.o_cmt_wdata <= h_wdata;
        bus.o_instr_cnt <= bus.o_instr_cnt + 64'd1;
      end
      bus.o_intr_no <= bus.i_intrNo;
      bus.o_intr_pc <= (bus.i_intrNo != '0) ? bus.i_pc[XLEN-1:0] : '0;
      // An interrupt cycle discards lanes on purpose, so it never counts as overflow.
      if ((bus.i_valid != '0) && !ready && (bus.i_intrNo == '0)) bus.o_overflow <= 1'b1;
      if (trap_hit) begin
        bus.o_trap_code <= h_code;
        bus.o_trap_pc   <= h_pc;
      end
      if (state == ST_RUN) bus.o_cycle_cnt <= bus.o_cycle_cnt + 64'd1;
    end
  end

endmodule

// File: tb/tb_cmt_trace_queue.sv
// Self-checking bench for cmt_trace_queue: queue model as scoreboard, vector table
// for the basic lane patterns, hand sequences for fill, interrupt, wrap, trap and reset.
module tb_cmt_trace_queue;

  localparam int unsigned NIN   = 2;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned XLEN  = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cmt_trace_queue_if #(.NIN(NIN), .DEPTH(DEPTH), .XLEN(XLEN)) bus ();

  cmt_trace_queue #(.NIN(NIN), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        skip;
    logic        wen;
    logic [4:0]  rd;
    logic [63:0] wdata;
    logic        trap;
    logic [7:0]  code;
  } ent_t;

  typedef struct {
    logic [1:0]  v;
    logic [63:0] pc0;
    logic [63:0] pc1;
    logic [31:0] i0;
    logic [31:0] i1;
    logic        exp_ready;
    logic [3:0]  exp_occ;
    logic [63:0] exp_instr;
  } vec_t;

  ent_t        mq[$];
  int          checks = 0;
  int          errors = 0;
  logic        m_trap, m_ovf;
  logic [63:0] m_cycle, m_instr, m_trap_pc;
  logic [7:0]  m_code;
  logic [63:0] a0_val = 64'h1234_5678_9abc_de55;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] TRAP = 32'h0000_006b;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic ent_t mk(input logic [63:0] pc, input logic [31:0] inst);
    ent_t e;
    e.pc    = pc;
    e.inst  = inst;
    e.skip  = pc[2];
    e.wen   = ~pc[3];
    e.rd    = pc[8:4];
    e.wdata = {pc[31:0], ~pc[31:0]};
    e.trap  = (inst[6:0] == 7'h6b);
    e.code  = 8'h00;
    return e;
  endfunction

  task automatic drive_idle();
    bus.i_valid    = '0;
    bus.i_pc       = '0;
    bus.i_inst     = '0;
    bus.i_rd_wen   = '0;
    bus.i_rd       = '0;
    bus.i_rd_wdata = '0;
    bus.i_skip     = '0;
    bus.i_a0       = a0_val;
    bus.i_intrNo   = '0;
  endtask

  task automatic clear_model();
    mq.delete();
    m_trap    = 1'b0;
    m_ovf     = 1'b0;
    m_cycle   = '0;
    m_instr   = '0;
    m_trap_pc = '0;
    m_code    = '0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    repeat (n) @(posedge clk);
    #1;
    clear_model();
    chk("rst_cmt_valid", bus.o_cmt_valid, 0);
    chk("rst_cmt_pc",    bus.o_cmt_pc, 0);
    chk("rst_cmt_inst",  bus.o_cmt_inst, 0);
    chk("rst_cmt_skip",  bus.o_cmt_skip, 0);
    chk("rst_cmt_wen",   bus.o_cmt_wen, 0);
    chk("rst_cmt_wdest", bus.o_cmt_wdest, 0);
    chk("rst_cmt_wdata", bus.o_cmt_wdata, 0);
    chk("rst_intr_no",   bus.o_intr_no, 0);
    chk("rst_intr_pc",   bus.o_intr_pc, 0);
    chk("rst_trap",      bus.o_trap, 0);
    chk("rst_trap_code", bus.o_trap_code, 0);
    chk("rst_trap_pc",   bus.o_trap_pc, 0);
    chk("rst_cycle",     bus.o_cycle_cnt, 0);
    chk("rst_instr",     bus.o_instr_cnt, 0);
    chk("rst_occ",       bus.o_occupancy, 0);
    chk("rst_overflow",  bus.o_overflow, 0);
    chk("rst_ready",     bus.o_ready, 1);
    rst = 1'b1;
  endtask

  // One clock: drive lanes, check ready before the edge, then the scoreboard after it.
  task automatic step(input logic [1:0] v, input logic [63:0] pc0, input logic [63:0] pc1,
                      input logic [31:0] inst0, input logic [31:0] inst1,
                      input logic [31:0] intr, output logic rdy_seen);
    ent_t e[2];
    ent_t h;
    logic exp_ready, exp_cv;
    @(negedge clk);
    e[0] = mk(pc0, inst0);
    e[1] = mk(pc1, inst1);
    bus.i_valid    = v;
    bus.i_pc       = {pc1, pc0};
    bus.i_inst     = {inst1, inst0};
    bus.i_rd_wen   = {e[1].wen, e[0].wen};
    bus.i_rd       = {e[1].rd, e[0].rd};
    bus.i_rd_wdata = {e[1].wdata, e[0].wdata};
    bus.i_skip     = {e[1].skip, e[0].skip};
    bus.i_a0       = a0_val;
    bus.i_intrNo   = intr;
    #1;
    exp_ready = !m_trap && ((int'(DEPTH) - mq.size()) >= int'(NIN));
    exp_cv    = (mq.size() > 0) && !m_trap;
    rdy_seen  = bus.o_ready;
    chk("ready", bus.o_ready, exp_ready);
    @(posedge clk);
    #1;
    if (!m_trap) m_cycle++;
    chk("cmt_valid", bus.o_cmt_valid, exp_cv);
    if (exp_cv) begin
      h = mq.pop_front();
      m_instr++;
      chk("cmt_pc",    bus.o_cmt_pc, h.pc);
      chk("cmt_inst",  bus.o_cmt_inst, h.inst);
      chk("cmt_skip",  bus.o_cmt_skip, h.skip);
      chk("cmt_wen",   bus.o_cmt_wen, h.wen);
      chk("cmt_wdest", bus.o_cmt_wdest, {3'd0, h.rd});
      chk("cmt_wdata", bus.o_cmt_wdata, h.wdata);
      if (h.trap) begin
        m_trap    = 1'b1;
        m_trap_pc = h.pc;
        m_code    = h.code;
      end
    end
    if (exp_ready && intr == 0) begin
      for (int k = 0; k < 2; k++) begin
        if (v[k]) begin
          e[k].code = e[k].trap ? a0_val[7:0] : 8'h00;
          mq.push_back(e[k]);
        end
      end
    end
    if (v != 0 && !exp_ready && intr == 0) m_ovf = 1'b1;
    chk("occupancy", bus.o_occupancy, 64'(mq.size()));
    chk("cycle_cnt", bus.o_cycle_cnt, m_cycle);
    chk("instr_cnt", bus.o_instr_cnt, m_instr);
    chk("trap",      bus.o_trap, m_trap);
    chk("trap_pc",   bus.o_trap_pc, m_trap_pc);
    chk("trap_code", bus.o_trap_code, m_code);
    chk("overflow",  bus.o_overflow, m_ovf);
    chk("intr_no",   bus.o_intr_no, intr);
    chk("intr_pc",   bus.o_intr_pc, (intr != 0) ? pc0 : 64'd0);
  endtask

  task automatic idle(output logic rdy_seen);
    step(2'b00, 64'd0, 64'd0, NOP, NOP, 32'd0, rdy_seen);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[7];
    logic        rdy;
    int          accepted, attempts;
    logic [63:0] cyc_frozen, instr_frozen, instr_base;

    tbl[0] = '{2'b01, 64'h8000_0000, 64'h0,           NOP,          NOP,          1'b1, 4'd1, 64'd0};
    tbl[1] = '{2'b11, 64'h8000_0004, 64'h8000_0008,   32'h0010_0093, 32'h0020_0113, 1'b1, 4'd2, 64'd1};
    tbl[2] = '{2'b00, 64'h0,         64'h0,           NOP,          NOP,          1'b1, 4'd1, 64'd2};
    tbl[3] = '{2'b00, 64'h0,         64'h0,           NOP,          NOP,          1'b1, 4'd0, 64'd3};
    tbl[4] = '{2'b10, 64'h0,         64'h8000_0010,   NOP,          32'h0030_0193, 1'b1, 4'd1, 64'd3};
    tbl[5] = '{2'b01, 64'h8000_0014, 64'h0,           32'h0040_0213, NOP,          1'b1, 4'd1, 64'd4};
    tbl[6] = '{2'b00, 64'h0,         64'h0,           NOP,          NOP,          1'b1, 4'd0, 64'd5};

    drive_idle();
    clear_model();
    do_reset(3);

    idle(rdy);
    chk("first_cycle_cnt", bus.o_cycle_cnt, 64'd1);

    for (int i = 0; i < 7; i++) begin
      step(tbl[i].v, tbl[i].pc0, tbl[i].pc1, tbl[i].i0, tbl[i].i1, 32'd0, rdy);
      chk("tbl_ready", rdy, tbl[i].exp_ready);
      chk("tbl_occ",   bus.o_occupancy, tbl[i].exp_occ);
      chk("tbl_instr", bus.o_instr_cnt, 64'd1 + tbl[i].exp_instr - 64'd1);
    end

    // Fill with two lanes per cycle against a one-per-cycle drain until ready drops.
    accepted = 0;
    attempts = 0;
    for (int n = 0; n < 10; n++) begin
      attempts++;
      step(2'b11, 64'h8000_1000 + 64'(16*n), 64'h8000_1008 + 64'(16*n),
           NOP, 32'h0050_0293, 32'd0, rdy);
      if (!rdy) break;
      accepted++;
    end
    chk("fill_accepted", 64'(accepted), 64'd6);
    chk("fill_overflow", bus.o_overflow, 1);
    for (int n = 0; n < 20 && mq.size() > 0; n++) idle(rdy);
    chk("fill_drained", bus.o_occupancy, 0);
    chk("fill_sb_empty", 64'(mq.size()), 0);

    // Interrupt cycle: lane discarded, record registered.
    instr_base = bus.o_instr_cnt;
    step(2'b01, 64'h8000_0100, 64'h0, NOP, NOP, 32'd7, rdy);
    chk("intr_no_7",  bus.o_intr_no, 64'd7);
    chk("intr_pc",    bus.o_intr_pc, 64'h8000_0100);
    idle(rdy);
    chk("intr_no_clear", bus.o_intr_no, 0);
    chk("intr_no_commit", bus.o_instr_cnt, instr_base);

    // Single-lane pushes interleaved with drains carry the pointers around several times.
    for (int n = 0; n < 20; n++) begin
      step(2'b01, 64'h8000_2000 + 64'(4*n), 64'h0, NOP, NOP, 32'd0, rdy);
      chk("wrap_occ_bound", 64'(bus.o_occupancy <= DEPTH), 1);
      idle(rdy);
    end
    chk("wrap_empty", bus.o_occupancy, 0);

    // Trap behind two entries, a0 low byte zero.
    instr_base = bus.o_instr_cnt;
    step(2'b11, 64'h8000_3000, 64'h8000_3004, NOP, 32'h0060_0313, 32'd0, rdy);
    a0_val = 64'hdead_beef_0000_0000;
    step(2'b01, 64'h8000_3008, 64'h0, TRAP, NOP, 32'd0, rdy);
    a0_val = 64'h1234_5678_9abc_de55;
    for (int n = 0; n < 10 && !bus.o_trap; n++) idle(rdy);
    chk("trap_set",     bus.o_trap, 1);
    chk("trap_pc_val",  bus.o_trap_pc, 64'h8000_3008);
    chk("trap_code_0",  bus.o_trap_code, 0);
    chk("trap_commits", bus.o_instr_cnt - instr_base, 64'd3);
    cyc_frozen   = m_cycle;
    instr_frozen = m_instr;
    repeat (10) idle(rdy);
    chk("frozen_cycle", bus.o_cycle_cnt, cyc_frozen);
    chk("frozen_instr", bus.o_instr_cnt, instr_frozen);
    chk("frozen_ready", bus.o_ready, 0);

    // Reset clears the trap; a second reset lands with entries still queued.
    do_reset(1);
    step(2'b11, 64'h8000_5000, 64'h8000_5004, NOP, NOP, 32'd0, rdy);
    step(2'b11, 64'h8000_5008, 64'h8000_500c, NOP, NOP, 32'd0, rdy);
    do_reset(1);
    idle(rdy);
    chk("post_rst_no_cmt", bus.o_cmt_valid, 0);

    // Trap straight into an empty queue, nonzero exit code.
    a0_val = 64'h0000_0000_0000_002a;
    step(2'b01, 64'h8000_4000, 64'h0, TRAP, NOP, 32'd0, rdy);
    a0_val = 64'h1234_5678_9abc_de55;
    for (int n = 0; n < 5 && !bus.o_trap; n++) idle(rdy);
    chk("trap2_code", bus.o_trap_code, 64'h2a);
    chk("trap2_pc",   bus.o_trap_pc, 64'h8000_4000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
